// File: rtl/exc_pkg.sv
// ============================================================================
// Module   : exc_pkg
// Brief    : Shared types and constants for the exception controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package exc_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HANDLER = 2'd1,
        HALT    = 2'd2
    } exc_state_t;

    localparam logic [3:0] ES_NONE    = 4'b0000;
    localparam logic [3:0] ES_IRQ     = 4'b0001;
    localparam logic [3:0] ES_ILLEGAL = 4'b0010;
    localparam logic [3:0] ES_DFAULT  = 4'b1111;

    localparam logic [1:0] MRS_ELR    = 2'd0;
    localparam logic [1:0] MRS_ESR    = 2'd1;
    localparam logic [1:0] MRS_STATUS = 2'd2;
    localparam logic [1:0] MRS_COUNT  = 2'd3;

    localparam int CNT_W = 32;

endpackage

`default_nettype wire

// File: rtl/exc_mrs_mux.sv
// ============================================================================
// Module   : exc_mrs_mux
// Brief    : Combinational MRS read-data selector for exception registers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module exc_mrs_mux
    import exc_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [1:0]       i_sel,
    input  logic [N-1:0]     i_elr,
    input  logic [3:0]       i_esr,
    input  logic             i_halt,
    input  logic             i_in_handler,
    input  logic [CNT_W-1:0] i_count,
    output logic [N-1:0]     o_data
);

    always_comb begin
        o_data = '0;
        case (i_sel)
            MRS_ELR:    o_data = i_elr;
            MRS_ESR:    o_data = {{(N-4){1'b0}}, i_esr};
            MRS_STATUS: o_data = {{(N-2){1'b0}}, i_halt, i_in_handler};
            default:    o_data = {{(N-CNT_W){1'b0}}, i_count};
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/exc_ctrl.sv
// ============================================================================
// Module   : exc_ctrl
// Brief    : Exception controller: ELR/ESR/mode, fetch redirect, side-effect
//            kill. Optional exception counter enabled by macro EXC_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module exc_ctrl
    import exc_pkg::*;
#(
    parameter int          N           = 64,
    parameter logic [N-1:0] VECTOR_ADDR = 64'hD8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         InstrValid,
    input  logic [N-1:0] PC,
    input  logic         NotAnInstr,
    input  logic [3:0]   EStatus,
    input  logic         ERet,
    input  logic         ExtIRQ,
    output logic         ExtIAck,
    output logic         Exc,
    output logic [N-1:0] ExcVector,
    output logic         ERetTaken,
    output logic [N-1:0] ELR,
    output logic [3:0]   ESR,
    output logic         Kill,
    output logic         InHandler,
    output logic         Halt,
    input  logic [1:0]   MrsSel,
    output logic [N-1:0] MrsData
);

    localparam logic [N-1:0] c_PC_INC = N'(4);

    exc_state_t       r_state, w_next_state;
    logic [N-1:0]     r_elr, w_elr_next;
    logic [3:0]       r_esr, w_esr_next;
    logic [CNT_W-1:0] w_count;

    // Reset gates every strobe so a same-cycle event cannot leak out.
    always_comb begin
        w_next_state = r_state;
        w_elr_next   = r_elr;
        w_esr_next   = r_esr;
        Exc          = 1'b0;
        ERetTaken    = 1'b0;
        Kill         = 1'b0;
        ExtIAck      = 1'b0;
        if (!reset && InstrValid) begin
            case (r_state)
                RUN: begin
                    if (NotAnInstr || ERet) begin
                        Exc          = 1'b1;
                        Kill         = 1'b1;
                        w_elr_next   = PC + c_PC_INC;
                        w_esr_next   = NotAnInstr ? EStatus : ES_ILLEGAL;
                        w_next_state = HANDLER;
                    end else if (ExtIRQ) begin
                        Exc          = 1'b1;
                        Kill         = 1'b1;
                        ExtIAck      = 1'b1;
                        w_elr_next   = PC;
                        w_esr_next   = ES_IRQ;
                        w_next_state = HANDLER;
                    end
                end
                HANDLER: begin
                    if (NotAnInstr) begin
                        Kill         = 1'b1;
                        w_esr_next   = ES_DFAULT;
                        w_next_state = HALT;
                    end else if (ERet) begin
                        ERetTaken    = 1'b1;
                        w_next_state = RUN;
                    end
                end
                HALT:    Kill = 1'b1;
                default: w_next_state = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_elr   <= '0;
            r_esr   <= ES_NONE;
        end else begin
            r_state <= w_next_state;
            r_elr   <= w_elr_next;
            r_esr   <= w_esr_next;
        end
    end

`ifdef EXC_COUNT_EN
    logic [CNT_W-1:0] r_exc_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_exc_count <= '0;
        end else if (Exc && (r_exc_count != '1)) begin
            r_exc_count <= r_exc_count + 1'b1;
        end
    end

    assign w_count = r_exc_count;
`else
    assign w_count = '0;
`endif

    assign ExcVector = VECTOR_ADDR;
    assign ELR       = r_elr;
    assign ESR       = r_esr;
    assign InHandler = (r_state == HANDLER);
    assign Halt      = (r_state == HALT);

    exc_mrs_mux #(
        .N (N)
    ) u_mrs_mux (
        .i_sel        (MrsSel),
        .i_elr        (r_elr),
        .i_esr        (r_esr),
        .i_halt       (Halt),
        .i_in_handler (InHandler),
        .i_count      (w_count),
        .o_data       (MrsData)
    );

endmodule

`default_nettype wire

// File: tb/tb_exc_ctrl.sv
// ============================================================================
// Module   : tb_exc_ctrl
// Brief    : Self-checking bench for exc_ctrl: directed vector table followed
//            by randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        InstrValid;
    logic [63:0] PC;
    logic        NotAnInstr;
    logic [3:0]  EStatus;
    logic        ERet;
    logic        ExtIRQ;
    logic        ExtIAck;
    logic        Exc;
    logic [63:0] ExcVector;
    logic        ERetTaken;
    logic [63:0] ELR;
    logic [3:0]  ESR;
    logic        Kill;
    logic        InHandler;
    logic        Halt;
    logic [1:0]  MrsSel;
    logic [63:0] MrsData;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    exc_ctrl #(
        .N           (64),
        .VECTOR_ADDR (64'hD8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .InstrValid (InstrValid),
        .PC         (PC),
        .NotAnInstr (NotAnInstr),
        .EStatus    (EStatus),
        .ERet       (ERet),
        .ExtIRQ     (ExtIRQ),
        .ExtIAck    (ExtIAck),
        .Exc        (Exc),
        .ExcVector  (ExcVector),
        .ERetTaken  (ERetTaken),
        .ELR        (ELR),
        .ESR        (ESR),
        .Kill       (Kill),
        .InHandler  (InHandler),
        .Halt       (Halt),
        .MrsSel     (MrsSel),
        .MrsData    (MrsData)
    );

    typedef struct {
        logic        rst;
        logic        v;
        logic [63:0] pc;
        logic        nai;
        logic [3:0]  es;
        logic        eret;
        logic        irq;
        logic        e_exc;
        logic        e_ert;
        logic        e_kill;
        logic        e_ack;
        logic [63:0] e_elr;
        logic [3:0]  e_esr;
        logic        e_inh;
        logic        e_halt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic v, logic [63:0] pc, logic nai,
                                logic [3:0] es, logic eret, logic irq,
                                logic exc, logic ert, logic kill, logic ack,
                                logic [63:0] elr, logic [3:0] esr,
                                logic inh, logic halt);
        vec_t r;
        r.rst = rst; r.v = v; r.pc = pc; r.nai = nai; r.es = es;
        r.eret = eret; r.irq = irq;
        r.e_exc = exc; r.e_ert = ert; r.e_kill = kill; r.e_ack = ack;
        r.e_elr = elr; r.e_esr = esr; r.e_inh = inh; r.e_halt = halt;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_mrs(logic [1:0] sel, logic [63:0] elr, logic [3:0] esr,
                                            logic halt, logic inh, logic [31:0] cnt);
        logic [63:0] r;
        case (sel)
            2'd0:    r = elr;
            2'd1:    r = {60'd0, esr};
            2'd2:    r = {62'd0, halt, inh};
`ifdef EXC_COUNT_EN
            default: r = {32'd0, cnt};
`else
            default: r = 64'd0;
`endif
        endcase
        return r;
    endfunction

    task automatic drive(input logic rst, input logic v, input logic [63:0] pc, input logic nai,
                         input logic [3:0] es, input logic eret, input logic irq, input logic [1:0] sel);
        @(negedge clk);
        reset = rst; InstrValid = v; PC = pc; NotAnInstr = nai;
        EStatus = es; ERet = eret; ExtIRQ = irq; MrsSel = sel;
        #1;
    endtask

    task automatic check_all(input logic exc, input logic ert, input logic kill, input logic ack,
                             input logic [63:0] elr, input logic [3:0] esr, input logic inh,
                             input logic halt, input logic [31:0] cnt);
        check("Exc", 64'(Exc), 64'(exc));
        check("ERetTaken", 64'(ERetTaken), 64'(ert));
        check("Kill", 64'(Kill), 64'(kill));
        check("ExtIAck", 64'(ExtIAck), 64'(ack));
        check("ELR", ELR, elr);
        check("ESR", 64'(ESR), 64'(esr));
        check("InHandler", 64'(InHandler), 64'(inh));
        check("Halt", 64'(Halt), 64'(halt));
        check("MrsData", MrsData, exp_mrs(MrsSel, elr, esr, halt, inh, cnt));
    endtask

    // Behavioural model state: 0 = running, 1 = in handler, 2 = halted.
    int          m_mode;
    logic [63:0] m_elr;
    logic [3:0]  m_esr;
    logic [31:0] m_cnt;

    initial begin
        logic [31:0] tcount;
        logic        irq_pend;

        reset = 1'b1; InstrValid = 1'b0; PC = '0; NotAnInstr = 1'b0;
        EStatus = '0; ERet = 1'b0; ExtIRQ = 1'b0; MrsSel = 2'd0;
        repeat (2) @(posedge clk);

        // Directed table: register expectations are the values held before the row's edge.
        tbl.push_back(mk(0,1,64'h40,1,4'h2,0,0, 1,0,1,0, 64'h0,  4'h0,0,0));
        tbl.push_back(mk(0,0,64'h50,0,4'h0,0,0, 0,0,0,0, 64'h44, 4'h2,1,0));
        tbl.push_back(mk(0,1,64'h44,0,4'h0,1,0, 0,1,0,0, 64'h44, 4'h2,1,0));
        tbl.push_back(mk(0,1,64'h100,0,4'h0,0,1,1,0,1,1, 64'h44, 4'h2,0,0));
        tbl.push_back(mk(0,1,64'hD8,0,4'h0,0,1, 0,0,0,0, 64'h100,4'h1,1,0));
        tbl.push_back(mk(0,1,64'hDC,0,4'h0,1,0, 0,1,0,0, 64'h100,4'h1,1,0));
        tbl.push_back(mk(0,1,64'h200,1,4'h5,0,1,1,0,1,0, 64'h100,4'h1,0,0));
        tbl.push_back(mk(0,1,64'hD8,0,4'h0,1,1, 0,1,0,0, 64'h204,4'h5,1,0));
        tbl.push_back(mk(0,1,64'h204,0,4'h0,0,1,1,0,1,1, 64'h204,4'h5,0,0));
        tbl.push_back(mk(0,1,64'hD8,1,4'h3,0,0, 0,0,1,0, 64'h204,4'h1,1,0));
        tbl.push_back(mk(0,1,64'hDC,0,4'h0,0,0, 0,0,1,0, 64'h204,4'hF,0,1));
        tbl.push_back(mk(0,0,64'hE0,0,4'h0,0,0, 0,0,0,0, 64'h204,4'hF,0,1));
        tbl.push_back(mk(0,1,64'hE0,0,4'h0,1,1, 0,0,1,0, 64'h204,4'hF,0,1));
        tbl.push_back(mk(1,1,64'hE4,0,4'h0,1,0, 0,0,0,0, 64'h204,4'hF,0,1));
        tbl.push_back(mk(0,0,64'h0,0,4'h0,0,0,  0,0,0,0, 64'h0,  4'h0,0,0));
        tbl.push_back(mk(0,1,64'h300,0,4'h0,1,0,1,0,1,0, 64'h0,  4'h0,0,0));
        tbl.push_back(mk(0,0,64'h0,0,4'h0,0,0,  0,0,0,0, 64'h304,4'h2,1,0));
        tbl.push_back(mk(0,1,64'hD8,0,4'h0,1,0, 0,1,0,0, 64'h304,4'h2,1,0));
        tbl.push_back(mk(0,1,64'hFFFF_FFFF_FFFF_FFFE,1,4'h2,0,0, 1,0,1,0, 64'h304,4'h2,0,0));
        tbl.push_back(mk(0,0,64'h0,0,4'h0,0,0,  0,0,0,0, 64'h2,  4'h2,1,0));
        tbl.push_back(mk(0,1,64'hD8,0,4'h0,1,0, 0,1,0,0, 64'h2,  4'h2,1,0));
        tbl.push_back(mk(0,0,64'h8,0,4'h0,0,1,  0,0,0,0, 64'h2,  4'h2,0,0));
        tbl.push_back(mk(0,1,64'h10,0,4'h0,0,1, 1,0,1,1, 64'h2,  4'h2,0,0));

        tcount = 32'd0;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].v, tbl[i].pc, tbl[i].nai, tbl[i].es,
                  tbl[i].eret, tbl[i].irq, 2'(i % 4));
            check_all(tbl[i].e_exc, tbl[i].e_ert, tbl[i].e_kill, tbl[i].e_ack,
                      tbl[i].e_elr, tbl[i].e_esr, tbl[i].e_inh, tbl[i].e_halt, tcount);
            if (tbl[i].rst) tcount = 32'd0;
            else if (tbl[i].e_exc) tcount = tcount + 32'd1;
        end
        check("ExcVector", ExcVector, 64'hD8);

        // Counter: three exceptions from a fresh reset, then a reset racing an ERet.
        drive(1,0,64'h0,0,4'h0,0,0,2'd3);
        drive(0,1,64'h20,1,4'h2,0,0,2'd3);
        drive(0,1,64'hD8,0,4'h0,1,0,2'd3);
        drive(0,1,64'h30,0,4'h0,0,1,2'd3);
        drive(0,1,64'hD8,0,4'h0,1,0,2'd3);
        drive(0,1,64'h40,0,4'h0,1,0,2'd3);
        drive(0,1,64'hD8,0,4'h0,1,1,2'd3);
`ifdef EXC_COUNT_EN
        check("count3", MrsData, 64'd3);
`else
        check("count3", MrsData, 64'd0);
`endif
        check("ERetTaken_pre_reset", 64'(ERetTaken), 64'd1);
        drive(1,1,64'hDC,0,4'h0,1,0,2'd3);
        check("ERetTaken_in_reset", 64'(ERetTaken), 64'd0);
        drive(0,0,64'h0,0,4'h0,0,0,2'd3);
        check("count_after_reset", MrsData, 64'd0);
        check("InHandler_after_reset", 64'(InHandler), 64'd0);

        // Randomized phase against the behavioural model.
        m_mode = 0; m_elr = '0; m_esr = 4'h0; m_cnt = 32'd0;
        irq_pend = 1'b0;
        for (int c = 0; c < 600; c++) begin
            logic        rst, v, nai, eret;
            logic [63:0] pc;
            logic [3:0]  es;
            logic        e_exc, e_ert, e_kill, e_ack;
            int          n_mode;
            logic [63:0] n_elr;
            logic [3:0]  n_esr;

            rst  = ($urandom_range(0, 79) == 0);
            v    = ($urandom_range(0, 3) != 0);
            nai  = ($urandom_range(0, 7) == 0);
            eret = ($urandom_range(0, 4) == 0);
            es   = 4'($urandom);
            pc   = ($urandom_range(0, 9) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                               : {$urandom, $urandom};
            drive(rst, v, pc, nai, es, eret, irq_pend, 2'($urandom));

            e_exc = 0; e_ert = 0; e_kill = 0; e_ack = 0;
            n_mode = m_mode; n_elr = m_elr; n_esr = m_esr;
            if (!rst && v) begin
                if (m_mode == 0 && (nai || eret)) begin
                    e_exc = 1; e_kill = 1; n_mode = 1;
                    n_elr = pc + 64'd4;
                    n_esr = nai ? es : 4'b0010;
                end else if (m_mode == 0 && irq_pend) begin
                    e_exc = 1; e_kill = 1; e_ack = 1; n_mode = 1;
                    n_elr = pc; n_esr = 4'b0001;
                end else if (m_mode == 1 && nai) begin
                    e_kill = 1; n_mode = 2; n_esr = 4'b1111;
                end else if (m_mode == 1 && eret) begin
                    e_ert = 1; n_mode = 0;
                end else if (m_mode == 2) begin
                    e_kill = 1;
                end
            end
            check_all(e_exc, e_ert, e_kill, e_ack, m_elr, m_esr,
                      m_mode == 1, m_mode == 2, m_cnt);

            if (rst) begin
                m_mode = 0; m_elr = '0; m_esr = 4'h0; m_cnt = 32'd0;
            end else begin
                m_mode = n_mode; m_elr = n_elr; m_esr = n_esr;
                if (e_exc && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            end
            if (e_ack) irq_pend = 1'b0;
            else if (!irq_pend && $urandom_range(0, 5) == 0) irq_pend = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
Exception controller that consumes the main decoder's exception outputs (NotAnInstr, EStatus, ERet) plus an external interrupt line. It owns the exception state (ELR, ESR, mode), redirects fetch to the handler vector or back to ELR, and kills the offending instruction's side effects. It sits beside the PC mux and register file write-enable, and serves MRS reads of ELR/ESR.

Parameters:
N, 64, datapath/PC width
VECTOR_ADDR, 64'hD8, handler entry address (N bits)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
InstrValid  in  1  current instruction is valid (not a bubble)
PC  in  N  PC of current instruction
NotAnInstr  in  1  decoder flag: illegal opcode
EStatus  in  4  decoder exception code
ERet  in  1  decoder flag: ERET instruction
ExtIRQ  in  1  external interrupt request, level
ExtIAck  out  1  one-cycle interrupt acknowledge
Exc  out  1  redirect PC to VECTOR_ADDR this cycle
ExcVector  out  N  constant VECTOR_ADDR
ERetTaken  out  1  redirect PC to ELR this cycle
ELR  out  N  exception link register
ESR  out  4  exception syndrome register
Kill  out  1  suppress RegWrite/MemWrite of current instruction
InHandler  out  1  state == HANDLER
Halt  out  1  state == HALT (double fault)
MrsSel  in  2  MRS source: 0 ELR, 1 ESR (zero-extended), 2 {N-2 zeros, Halt, InHandler}, 3 counter or 0
MrsData  out  N  combinational MRS read data

Behaviour:
- Reset: state RUN, ELR=0, ESR=0; ExtIAck=Exc=ERetTaken=Kill=0; InHandler=Halt=0. Reset overrides any same-cycle event.
- States: RUN, HANDLER, HALT. Exc, ERetTaken, Kill, ExtIAck are combinational in the event cycle t; register updates occur at the edge ending t.
- Event set (only when InValid=1): sync = NotAnInstr, or ERet in RUN (treated as illegal, code 4'b0010); irq = ExtIRQ.
- RUN, priority sync > irq:
  - sync: Exc=1, Kill=1; ELR<=PC+4; ESR<=EStatus (4'b0010 for ERet-in-RUN); -> HANDLER.
  - irq, no sync: Exc=1, Kill=1, ExtIAck=1; ELR<=PC (instruction re-executes); ESR<=4'b0001; -> HANDLER.
  - no event: outputs 0, hold.
- HANDLER:
  - ERet && !NotAnInstr: ERetTaken=1, Kill=0; -> RUN next cycle; ELR, ESR hold.
  - NotAnInstr (double fault): Kill=1, Exc=0; ESR<=4'b1111; ELR holds; -> HALT.
  - ExtIRQ ignored: no ack, stays pending.
- HALT: Kill=1 whenever InValid; all redirects 0; exits only on reset.
- ExtIRQ handshake: requester holds ExtIRQ until ExtIAck and drops it the cycle after. An IRQ still high on return to RUN is taken again; a same-cycle ERet/IRQ in HANDLER returns first, then takes the IRQ next valid cycle.
- InValid=0: no event in any state; state and registers hold.
- PC+4 wraps modulo 2^N.

Optional Feature:
- Macro EXC_COUNT_EN.
- Defined: 32-bit counter, reset 0, +1 on every Exc=1 cycle, saturates at 32'hFFFF_FFFF; MrsSel=3 returns it zero-extended.
- Undefined: no counter; MrsSel=3 returns 0.

Decomposition:
- Package exc_pkg:
  - state enum exc_state_t {RUN, HANDLER, HALT}
  - EStatus constants ES_NONE=4'b0000, ES_IRQ=4'b0001, ES_ILLEGAL=4'b0010, ES_DFAULT=4'b1111
  - MRS selector constants
- The decoder imports ES_ILLEGAL from the same package.
- One sub-module is natural: exc_mrs_mux (MrsSel to MrsData). The FSM and registers stay in exc_ctrl.

Test Plan:
- Illegal op, PC=0x40, NotAnInstr=1, EStatus=0010 -> Exc=1, Kill=1 same cycle; next: ELR=0x44, ESR=0010, InHandler=1.
- ExtIRQ=1 at PC=0x100, no sync -> ExtIAck pulse 1 cycle; ELR=0x100, ESR=0001; ExtIRQ held in HANDLER produces no second ack.
- In HANDLER, ERet=1 -> ERetTaken=1, Kill=0; next cycle InHandler=0, ELR still 0x44.
- NotAnInstr and ExtIRQ same cycle in RUN -> sync wins, ExtIAck=0, ESR=0010; IRQ taken after return.
- NotAnInstr in HANDLER -> ESR=1111, Halt=1, ELR unchanged; later instructions Kill=1; reset -> RUN with all registers 0.
- EXC_COUNT_EN: three exceptions, MrsSel=3 -> MrsData=3; reset with ERet asserted the same cycle -> counter 0, ERetTaken=0.
